// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
// Stall/flush controller for the 5-stage pipeline. It covers three cases
// that operand bypassing cannot: load-use hazards, branches resolved taken
// in MEM, and multi-cycle EX operations.
// Optional build macro: HAZARD_STATS_EN adds the stall_cycles and
// flush_events counters and their output ports.
module hazard_detection_unit #(
    parameter int MC_LATENCY = 4,   // total EX cycles of a multi-cycle op (2..16)
    parameter int CNT_W      = 4    // wide enough to hold MC_LATENCY-2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_Rs_addr,
    input  logic [4:0] ID_Rt_addr,
    input  logic       ID_uses_Rt,
    input  logic [4:0] ID_EX_Rt_addr,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_MultiCycle,
    input  logic       branch_taken,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_Mem_Flush,
    output logic       busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             load_use;

    // The load in EX writes a register that the instruction in ID reads.
    // $0 is never a real destination, so it never stalls.
    assign load_use = ID_EX_MemRead && (ID_EX_Rt_addr != 5'd0) &&
                      ((ID_EX_Rt_addr == ID_Rs_addr) ||
                       (ID_uses_Rt && (ID_EX_Rt_addr == ID_Rt_addr)));

    // State and wait-counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and Mealy outputs. Priority: branch > multi-cycle > load-use.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_Mem_Flush = 1'b0;
        busy         = 1'b0;

        if (rst_i) begin
            // Hold the whole front end frozen and flushed while in reset.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_Mem_Flush = 1'b1;
            state_next   = RUN;
            cnt_next     = '0;
        end else if (branch_taken) begin
            // Squash everything younger than the branch, including any
            // multi-cycle op still in EX (this is the abort path).
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_Mem_Flush = 1'b1;
            state_next   = RUN;
            cnt_next     = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ID_EX_MultiCycle) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_Mem_Flush = 1'b1;
                        busy         = 1'b1;
                        state_next   = MC_WAIT;
                        // The entry cycle and the advance cycle both count
                        // towards EX occupancy, hence the -2.
                        cnt_next     = CNT_W'(MC_LATENCY - 2);
                    end else if (load_use) begin
                        // One bubble; it clears itself since it has MemRead=0.
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Flush  = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (cnt_reg != '0) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_Mem_Flush = 1'b1;
                        busy         = 1'b1;
                        cnt_next     = cnt_reg - 1'b1;
                    end else begin
                        // Advance cycle: the op leaves EX. A younger
                        // instruction can still raise a load-use stall here.
                        if (load_use) begin
                            PC_Write    = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_Flush = 1'b1;
                        end
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    // Free-running statistics; both wrap on overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!PC_Write)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken)
                flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Testbench for hazard_detection_unit. Two instances share one stimulus
// stream: dut4 with MC_LATENCY=4 and dut2 with MC_LATENCY=2. Expected
// outputs are queued when a vector is driven and compared on the falling edge.
module tb_hazard_detection_unit;

    // Output vector bit order:
    // {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_Mem_Flush, busy}
    localparam logic [6:0] DEF = 7'b1110000;
    localparam logic [6:0] RST = 7'b0001110;
    localparam logic [6:0] MC  = 7'b0000011;
    localparam logic [6:0] LU  = 7'b0010100;
    localparam logic [6:0] BR  = 7'b1111110;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic [4:0] exrt;
        logic       mr;
        logic       mc;
        logic       br;
        logic [6:0] e4;
        logic [6:0] e2;
    } vec_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [6:0]  e4;
        logic [6:0]  e2;
    } sb_t;

    logic       clk;
    logic       rst_i;
    logic [4:0] ID_Rs_addr;
    logic [4:0] ID_Rt_addr;
    logic       ID_uses_Rt;
    logic [4:0] ID_EX_Rt_addr;
    logic       ID_EX_MemRead;
    logic       ID_EX_MultiCycle;
    logic       branch_taken;

    logic pcw4, ifw4, idw4, iff4, idf4, exf4, busy4;
    logic pcw2, ifw2, idw2, iff2, idf2, exf2, busy2;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall4, stall2;
    logic [15:0] flush4, flush2;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   idx   = 0;
    sb_t  sb[$];
    vec_t vecs[26];

    hazard_detection_unit #(.MC_LATENCY(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i),
        .ID_Rs_addr(ID_Rs_addr), .ID_Rt_addr(ID_Rt_addr), .ID_uses_Rt(ID_uses_Rt),
        .ID_EX_Rt_addr(ID_EX_Rt_addr), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MultiCycle(ID_EX_MultiCycle), .branch_taken(branch_taken),
        .PC_Write(pcw4), .IF_ID_Write(ifw4), .ID_EX_Write(idw4),
        .IF_ID_Flush(iff4), .ID_EX_Flush(idf4), .EX_Mem_Flush(exf4), .busy(busy4)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall4), .flush_events(flush4)
`endif
    );

    hazard_detection_unit #(.MC_LATENCY(2), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst_i),
        .ID_Rs_addr(ID_Rs_addr), .ID_Rt_addr(ID_Rt_addr), .ID_uses_Rt(ID_uses_Rt),
        .ID_EX_Rt_addr(ID_EX_Rt_addr), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MultiCycle(ID_EX_MultiCycle), .branch_taken(branch_taken),
        .PC_Write(pcw2), .IF_ID_Write(ifw2), .ID_EX_Write(idw2),
        .IF_ID_Flush(iff2), .ID_EX_Flush(idf2), .EX_Mem_Flush(exf2), .busy(busy2)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall2), .flush_events(flush2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic [4:0] exrt, input logic mr,
                                input logic mc, input logic br,
                                input logic [6:0] e4, input logic [6:0] e2);
        vec_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.ur = ur; v.exrt = exrt;
        v.mr = mr; v.mc = mc; v.br = br; v.e4 = e4; v.e2 = e2;
        return v;
    endfunction

    // Drive one vector just after the rising edge and queue its expectation.
    task automatic step(input vec_t v);
        sb_t s;
        @(posedge clk);
        #1;
        rst_i            = v.rst;
        ID_Rs_addr       = v.rs;
        ID_Rt_addr       = v.rt;
        ID_uses_Rt       = v.ur;
        ID_EX_Rt_addr    = v.exrt;
        ID_EX_MemRead    = v.mr;
        ID_EX_MultiCycle = v.mc;
        branch_taken     = v.br;
        s.idx = idx; s.e4 = v.e4; s.e2 = v.e2;
        sb.push_back(s);
        idx++;
    endtask

    // Pop the expectation for the current cycle and compare both instances.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t s;
            logic [6:0] got4, got2;
            s    = sb.pop_front();
            got4 = {pcw4, ifw4, idw4, iff4, idf4, exf4, busy4};
            got2 = {pcw2, ifw2, idw2, iff2, idf2, exf2, busy2};
            n_cmp++;
            if (got4 !== s.e4) begin
                n_err++;
                $display("FAIL vec%0d_lat4: got %b want %b", s.idx, got4, s.e4);
            end
            n_cmp++;
            if (got2 !== s.e2) begin
                n_err++;
                $display("FAIL vec%0d_lat2: got %b want %b", s.idx, got2, s.e2);
            end
            $display("vec%0d lat4=%b lat2=%b", s.idx, got4, got2);
        end
    end

    initial begin
        rst_i = 1'b1; ID_Rs_addr = '0; ID_Rt_addr = '0; ID_uses_Rt = 1'b0;
        ID_EX_Rt_addr = '0; ID_EX_MemRead = 1'b0; ID_EX_MultiCycle = 1'b0;
        branch_taken = 1'b0;

        //                 rst rs     rt     ur    exrt   mr    mc    br    lat4 lat2
        vecs[0]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST, RST); // reset
        vecs[1]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF); // idle
        vecs[2]  = mk(1'b0, 5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LU,  LU ); // load-use Rs
        vecs[3]  = mk(1'b0, 5'd8, 5'd1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, DEF, DEF); // bubble clears
        vecs[4]  = mk(1'b0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, DEF, DEF); // Rt unused
        vecs[5]  = mk(1'b0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, LU,  LU ); // Rt used
        vecs[6]  = mk(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, DEF, DEF); // $0 never stalls
        vecs[7]  = mk(1'b0, 5'd3, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, DEF, DEF); // no match
        vecs[8]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ); // T
        vecs[9]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  DEF); // T+1
        vecs[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ); // T+2 (lat2 back-to-back)
        vecs[11] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DEF, DEF); // T+3 advance
        vecs[12] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ); // back-to-back, no gap
        vecs[13] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  DEF); // 1st MC_WAIT
        vecs[14] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BR,  BR ); // abort in 2nd MC_WAIT
        vecs[15] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF); // back in RUN
        vecs[16] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, BR,  BR ); // branch beats MC
        vecs[17] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF); // MC was squashed
        vecs[18] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ); // enter MC_WAIT
        vecs[19] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RST, RST); // reset mid-wait
        vecs[20] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF); // RUN after release
        vecs[21] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ); // enter MC_WAIT
        vecs[22] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  DEF);
        vecs[23] = mk(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, MC,  MC ); // load-use ignored / MC wins
        vecs[24] = mk(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LU,  LU ); // load-use in advance cycle
        vecs[25] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF);

        for (int i = 0; i < 26; i++)
            step(vecs[i]);

`ifdef HAZARD_STATS_EN
        // One load-use stall, one 4-cycle multi-cycle op, one branch.
        step(mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST, RST));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF));
        step(mk(1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, LU,  LU ));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  DEF));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MC,  MC ));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DEF, DEF));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BR,  BR ));
        step(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, DEF, DEF));
        @(negedge clk);
        #1;
        n_cmp++;
        if (stall4 !== 32'd4) begin
            n_err++;
            $display("FAIL stall_cycles_lat4: got %0d want 4", stall4);
        end
        n_cmp++;
        if (flush4 !== 16'd1) begin
            n_err++;
            $display("FAIL flush_events_lat4: got %0d want 1", flush4);
        end
        n_cmp++;
        if (stall2 !== 32'd3) begin
            n_err++;
            $display("FAIL stall_cycles_lat2: got %0d want 3", stall2);
        end
        $display("stats lat4 stall=%0d flush=%0d lat2 stall=%0d", stall4, flush4, stall2);
`endif

        // Let the scoreboard drain, bounded.
        for (int k = 0; k < 10 && sb.size() != 0; k++)
            @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
